// File: rtl/vs_quad_pkg.sv
// Package for the quadrature decoder.
// Holds the {A,B} state type, the four named Gray states, and the transition
// classifier used by the top-level decoder.
package vs_quad_pkg;

   typedef logic [1:0] quad_state_t;

   localparam quad_state_t Q00 = 2'b00;
   localparam quad_state_t Q10 = 2'b10;
   localparam quad_state_t Q11 = 2'b11;
   localparam quad_state_t Q01 = 2'b01;

   typedef struct packed {
      logic valid;    // exactly one phase changed
      logic up;       // direction of a valid change (A leads B = up)
      logic illegal;  // both phases changed in the same cycle
   } quad_dir_t;

   // Classify a prev->cur transition; up order is 00->10->11->01->00
   function automatic quad_dir_t quad_dir(input quad_state_t prev, input quad_state_t cur);
      quad_dir_t res;
      res = '{valid: 1'b0, up: 1'b0, illegal: 1'b0};
      case ({prev, cur})
         {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: begin
            res.valid = 1'b1;
            res.up    = 1'b1;
         end
         {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
            res.valid = 1'b1;
            res.up    = 1'b0;
         end
         {Q00, Q11}, {Q11, Q00}, {Q10, Q01}, {Q01, Q10}: begin
            res.illegal = 1'b1;
         end
         default: begin
            res = '{valid: 1'b0, up: 1'b0, illegal: 1'b0};
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/vs_glitch_filter.sv
// Synchroniser plus glitch filter for one encoder phase.
// Ports:
//   clock   - system clock (posedge)
//   reset_n - asynchronous active-low reset
//   din     - raw asynchronous pin
//   dout    - filtered level; flips only after FILTER_LEN consecutive
//             cycles in which the synchronised pin disagrees with it
module vs_glitch_filter
   import vs_quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   filt_r;
   logic                   sync_s;

   assign sync_s = sync_r[SYNC_STAGES-1];
   assign dout   = filt_r;

   // Metastability chain: shift the raw pin toward the filter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   // Qualification counter: any agreeing cycle restarts the count
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= '0;
         filt_r <= 1'b0;
      end else if (sync_s != filt_r) begin
         if (cnt_r == CNT_LAST) begin
            filt_r <= sync_s;
            cnt_r  <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r <= '0;
      end
   end

endmodule

// File: rtl/vs_quadrature_decoder.sv
// Quadrature decoder feeding vs_up_down_counter.
// Ports:
//   clock, reset_n - clock (posedge) and asynchronous active-low reset
//   a_in, b_in     - raw encoder phases, asynchronous to clock
//   enable         - gates step/err pulses; filters and prev keep tracking
//   clear_err      - synchronous clear of err_count
//   step, up       - one-cycle count strobe and its direction (up holds)
//   err            - one-cycle pulse when both phases change together
//   err_count      - saturating count of err pulses
//   a_filt, b_filt - filtered phase levels
module vs_quadrature_decoder
   import vs_quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             enable,
   input  logic             clear_err,
   output logic             step,
   output logic             up,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             a_filt,
   output logic             b_filt
);

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic             a_filt_s;
   logic             b_filt_s;
   quad_state_t      cur_s;
   quad_state_t      prev_r;
   quad_dir_t        dir_s;
   logic             step_r;
   logic             up_r;
   logic             err_r;
   logic [ERR_W-1:0] err_count_r;

   vs_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (a_in),
      .dout    (a_filt_s)
   );

   vs_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (b_in),
      .dout    (b_filt_s)
   );

   assign cur_s = {a_filt_s, b_filt_s};

   // Classify the filtered transition seen this cycle
   always_comb begin
      dir_s = quad_dir(prev_r, cur_s);
   end

   // Track previous state and register step/up/err pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_r <= Q00;
         step_r <= 1'b0;
         up_r   <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         prev_r <= cur_s;
         step_r <= dir_s.valid & enable;
         err_r  <= dir_s.illegal & enable;
         if (dir_s.valid) begin
            up_r <= dir_s.up;
         end else begin
            up_r <= up_r;
         end
      end
   end

   // Saturating error counter; a clear coinciding with an err pulse keeps that pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_count_r <= '0;
      end else if (clear_err) begin
         err_count_r <= err_r ? ERR_W'(1) : '0;
      end else if (err_r && (err_count_r != ERR_MAX)) begin
         err_count_r <= err_count_r + ERR_W'(1);
      end else begin
         err_count_r <= err_count_r;
      end
   end

   assign step      = step_r;
   assign up        = up_r;
   assign err       = err_r;
   assign err_count = err_count_r;
   assign a_filt    = a_filt_s;
   assign b_filt    = b_filt_s;

endmodule

// File: tb/tb_vs_quadrature_decoder.sv
module tb_vs_quadrature_decoder;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       a_in;
   logic       b_in;
   logic       enable;
   logic       clear_err;
   logic       step;
   logic       up;
   logic       err;
   logic [7:0] err_count;
   logic       a_filt;
   logic       b_filt;

   int tests = 0;
   int fails = 0;

   // Expected events: {err, step, up}
   localparam logic [2:0] EV_UP   = 3'b011;
   localparam logic [2:0] EV_DOWN = 3'b010;
   localparam logic [2:0] EV_ERR  = 3'b100;
   logic [2:0] exp_q[$];

   vs_quadrature_decoder dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .a_in      (a_in),
      .b_in      (b_in),
      .enable    (enable),
      .clear_err (clear_err),
      .step      (step),
      .up        (up),
      .err       (err),
      .err_count (err_count),
      .a_filt    (a_filt),
      .b_filt    (b_filt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every step/err pulse must match the oldest expected event
   always @(negedge clock) begin
      logic [2:0] obs;
      logic [2:0] expv;
      if (reset_n === 1'b1 && (step === 1'b1 || err === 1'b1)) begin
         obs = {err, step, step & up};
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_event observed=%b expected=none", obs);
         end
         if (exp_q.size() != 0) begin
            expv = exp_q.pop_front();
            tests++;
            assert (obs === expv) else begin
               fails++;
               $error("FAIL event observed=%b expected=%b", obs, expv);
            end
         end
      end
   end

   task automatic drive_ab(input logic a, input logic b, input logic push, input logic [2:0] ev);
      @(negedge clock);
      if (push) exp_q.push_back(ev);
      a_in = a;
      b_in = b;
      repeat (10) @(negedge clock);
   endtask

   initial begin
      reset_n   = 1'b0;
      a_in      = 1'b0;
      b_in      = 1'b0;
      enable    = 1'b1;
      clear_err = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", {step, up, err, err_count, a_filt, b_filt}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Forward sequence with latency check on the first edge
      exp_q.push_back(EV_UP);
      a_in = 1'b1;
      repeat (6) @(posedge clock);
      #1 check("step_before_latency", step, 1'b0);
      @(posedge clock);
      #1 check("step_at_latency", {step, up}, 2'b11);
      repeat (3) @(negedge clock);
      drive_ab(1'b1, 1'b1, 1'b1, EV_UP);
      drive_ab(1'b0, 1'b1, 1'b1, EV_UP);
      drive_ab(1'b0, 1'b0, 1'b1, EV_UP);
      check("fwd_all_seen", exp_q.size(), 32'd0);
      check("fwd_err_count", err_count, 32'd0);

      // Reverse sequence
      drive_ab(1'b0, 1'b1, 1'b1, EV_DOWN);
      drive_ab(1'b1, 1'b1, 1'b1, EV_DOWN);
      drive_ab(1'b1, 1'b0, 1'b1, EV_DOWN);
      drive_ab(1'b0, 1'b0, 1'b1, EV_DOWN);
      check("rev_all_seen", exp_q.size(), 32'd0);
      check("rev_up_holds", up, 1'b0);

      // Three-cycle glitch on A must never reach a_filt
      @(negedge clock);
      a_in = 1'b1;
      repeat (3) @(negedge clock);
      a_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("glitch_a_filt", a_filt, 1'b0);
         @(negedge clock);
      end
      check("glitch_err_count", err_count, 32'd0);

      // Double-edge transitions: err pulses and saturation
      for (int i = 0; i < 300; i++) begin
         drive_ab((i % 2 == 0), (i % 2 == 0), 1'b1, EV_ERR);
         check("err_count_sat", err_count, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      end
      check("err_all_seen", exp_q.size(), 32'd0);

      // Clear alone, then clear coinciding with an err pulse
      clear_err = 1'b1;
      @(negedge clock);
      clear_err = 1'b0;
      @(negedge clock);
      check("clear_alone", err_count, 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive_ab((i % 2 == 0), (i % 2 == 0), 1'b1, EV_ERR);
      end
      check("err_count_5", err_count, 32'd5);
      exp_q.push_back(EV_ERR);
      a_in = 1'b0;
      b_in = 1'b0;
      for (int i = 0; i < 20 && err !== 1'b1; i++) @(negedge clock);
      check("err_seen_for_clear", err, 1'b1);
      clear_err = 1'b1;
      @(negedge clock);
      clear_err = 1'b0;
      check("clear_with_err", err_count, 32'd1);
      repeat (2) @(negedge clock);
      clear_err = 1'b1;
      @(negedge clock);
      clear_err = 1'b0;
      @(negedge clock);
      check("clear_after", err_count, 32'd0);
      repeat (8) @(negedge clock);

      // enable=0 suppresses the step; re-enable gives one fresh step only
      enable = 1'b0;
      drive_ab(1'b1, 1'b0, 1'b0, EV_UP);
      check("disabled_a_filt", a_filt, 1'b1);
      enable = 1'b1;
      drive_ab(1'b1, 1'b1, 1'b1, EV_UP);
      check("reenable_all_seen", exp_q.size(), 32'd0);
      check("reenable_up", up, 1'b1);

      // Reset mid-filter clears everything at once, no stray step afterwards
      @(negedge clock);
      a_in = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check("midreset_outputs", {step, up, err, err_count, a_filt, b_filt}, 32'd0);
      a_in = 1'b0;
      b_in = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (15) @(negedge clock);
      check("post_reset_quiet", {exp_q.size(), a_filt, b_filt, up}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
